chunk_addr_looper: RTL and testbench

CHUNK_ADDR_LOOPER -- requirements
Module: ChunkAddrLooper

---
 rtl/chunk_addr_looper_pkg.sv | 22 ++
 rtl/chunk_addr_looper_nd_counter.sv | 62 ++++++
 rtl/chunk_addr_looper.sv | 189 ++++++++++++++++++
 tb/tb_chunk_addr_looper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_addr_looper_pkg.sv
// Shared configuration for the chunk address looper: default geometry,
// command length width and the looper FSM state type.
// Optional feature macro: CHUNK_ADDR_LOOPER_SPLIT_EN (row splitting into bursts).
package TauCfg;

  localparam int unsigned GLOBAL_ADDR_BW = 16;
  localparam int unsigned DIM            = 3;
  localparam int unsigned N_ICFG         = 2;
  localparam int unsigned MAX_BURST      = 4;

`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
  localparam int unsigned LEN_BW = $clog2(MAX_BURST + 1);
`else
  localparam int unsigned LEN_BW = GLOBAL_ADDR_BW;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } looper_state_e;

endpackage

// File: rtl/chunk_addr_looper_nd_counter.sv
// Multi-dimensional odometer: counter d runs 0..len[d]-1, the highest index
// varies fastest and carries toward index 0. o_last flags every counter at
// its final value.
module NDCounter #(
  parameter int unsigned BW  = 16,
  parameter int unsigned DIM = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_inc,
  input  logic [DIM-1:0][BW-1:0]  i_len,
  output logic [DIM-1:0][BW-1:0]  o_cnt,
  output logic                    o_last
);

  localparam logic [BW-1:0] ONE = BW'(1);

  logic [DIM-1:0][BW-1:0] cnt_q, cnt_d;
  logic [DIM-1:0]         at_end;
  logic                   carry;

  // Per-dimension final-value detection
  always_comb begin
    at_end = '0;
    for (int unsigned d = 0; d < DIM; d++) begin
      at_end[d] = (cnt_q[d] == i_len[d] - ONE);
    end
  end

  assign o_last = &at_end;
  assign o_cnt  = cnt_q;

  // Carry ripples from the fastest (highest index) dimension toward index 0
  always_comb begin
    cnt_d = cnt_q;
    carry = i_inc;
    for (int unsigned k = 0; k < DIM; k++) begin
      if (carry) begin
        if (at_end[DIM-1-k]) begin
          cnt_d[DIM-1-k] = '0;
        end else begin
          cnt_d[DIM-1-k] = cnt_q[DIM-1-k] + ONE;
          carry          = 1'b0;
        end
      end
    end
    if (i_clear) begin
      cnt_d = '0;
    end
  end

  // Counter state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chunk_addr_looper.sv
// Chunk address looper: accepts a chunk head (offset + per-config extent)
// and walks it as a sequence of row commands. Outer dimensions step as an
// odometer; the innermost dimension is emitted per row.
// Optional feature macro: CHUNK_ADDR_LOOPER_SPLIT_EN -- when defined, rows
// are split into commands of at most MAX_BURST words; otherwise one command
// per row with the full row length.
module chunk_addr_looper #(
  parameter  int unsigned GBW       = TauCfg::GLOBAL_ADDR_BW,
  parameter  int unsigned DIM       = TauCfg::DIM,
  parameter  int unsigned N_ICFG    = TauCfg::N_ICFG,
  parameter  int unsigned MAX_BURST = TauCfg::MAX_BURST,
  localparam int unsigned ICFG_BW   = $clog2(N_ICFG + 1),
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
  localparam int unsigned LEN_BW    = $clog2(MAX_BURST + 1)
`else
  localparam int unsigned LEN_BW    = GBW
`endif
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_mofs_rdy,
  output logic                                i_mofs_ack,
  input  logic [DIM-1:0][GBW-1:0]             i_mofs,
  input  logic [ICFG_BW-1:0]                  i_id,
  input  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0] i_mlen,
  output logic                                o_cmd_rdy,
  input  logic                                o_cmd_ack,
  output logic [DIM-1:0][GBW-1:0]             o_cmd_mofs,
  output logic [LEN_BW-1:0]                   o_cmd_len,
  output logic [ICFG_BW-1:0]                  o_cmd_id,
  output logic                                o_cmd_last
);

  import TauCfg::*;

  looper_state_e              state_q, state_d;
  logic [DIM-1:0][GBW-1:0]    base_q, base_d;
  logic [DIM-1:0][GBW-1:0]    len_q, len_d;
  logic [ICFG_BW-1:0]         id_q, id_d;
  logic [GBW-1:0]             w;
  logic [GBW-1:0]             rem;
  logic [LEN_BW-1:0]          cmd_len;
  logic                       row_end;
  logic                       cmd_last;
  logic [DIM-1:0][GBW-1:0]    sel_len;
  logic                       sel_zero;
  logic                       odo_clear;
  logic                       odo_inc;
  logic                       odo_last;
  logic [DIM-2:0][GBW-1:0]    cnt;

`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
  localparam logic [GBW-1:0] BURST_G = GBW'(MAX_BURST);
  logic [GBW-1:0] w_q, w_d;
  assign w = w_q;
`else
  assign w = '0;
`endif

  assign i_mofs_ack = (state_q == IDLE);
  assign o_cmd_rdy  = (state_q == RUN);

  // Extent lookup for the offered configuration; out-of-range ids read as empty
  always_comb begin
    sel_len = '0;
    for (int unsigned k = 0; k < N_ICFG; k++) begin
      if (i_id == ICFG_BW'(k)) begin
        sel_len = i_mlen[k];
      end
    end
    sel_zero = 1'b0;
    for (int unsigned d = 0; d < DIM; d++) begin
      if (sel_len[d] == '0) begin
        sel_zero = 1'b1;
      end
    end
  end

  // Current command length and end-of-row detection
  always_comb begin
    rem = len_q[DIM-1] - w;
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
    // rem <= MAX_BURST is equivalent to w + cmd_len reaching the row length
    row_end = (rem <= BURST_G);
    cmd_len = row_end ? LEN_BW'(rem) : LEN_BW'(MAX_BURST);
`else
    row_end = 1'b1;
    cmd_len = rem;
`endif
    cmd_last = odo_last & row_end;
  end

  // Command payload, held at zero whenever no command is offered
  always_comb begin
    o_cmd_mofs = '0;
    o_cmd_len  = '0;
    o_cmd_id   = '0;
    o_cmd_last = 1'b0;
    if (state_q == RUN) begin
      for (int unsigned d = 0; d < DIM - 1; d++) begin
        o_cmd_mofs[d] = base_q[d] + cnt[d];
      end
      o_cmd_mofs[DIM-1] = base_q[DIM-1] + w;
      o_cmd_len         = cmd_len;
      o_cmd_id          = id_q;
      o_cmd_last        = cmd_last;
    end
  end

  // FSM next-state: accept a chunk in IDLE, step row/odometer in RUN
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    id_d      = id_q;
    odo_clear = 1'b0;
    odo_inc   = 1'b0;
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
    w_d       = w_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_mofs_rdy) begin
          base_d    = i_mofs;
          len_d     = sel_len;
          id_d      = i_id;
          odo_clear = 1'b1;
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
          w_d       = '0;
`endif
          state_d   = sel_zero ? IDLE : RUN;
        end
      end
      RUN: begin
        if (o_cmd_ack) begin
          if (cmd_last) begin
            state_d = IDLE;
          end else if (row_end) begin
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
            w_d     = '0;
`endif
            odo_inc = 1'b1;
          end
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
          else begin
            w_d = w_q + GBW'(cmd_len);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and latched chunk registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
      w_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      id_q    <= id_d;
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
      w_q     <= w_d;
`endif
    end
  end

  NDCounter #(
    .BW  (GBW),
    .DIM (DIM - 1)
  ) u_odometer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (odo_clear),
    .i_inc   (odo_inc),
    .i_len   (len_q[DIM-2:0]),
    .o_cnt   (cnt),
    .o_last  (odo_last)
  );

endmodule

// File: tb/tb_chunk_addr_looper.sv
// Testbench for chunk_addr_looper (DIM=3, MAX_BURST=4). Expected commands
// come from a nested-loop reference model of the chunk walk.
// Honours CHUNK_ADDR_LOOPER_SPLIT_EN the same way as the design.
`timescale 1ns/1ps
module tb_chunk_addr_looper;

  localparam int GBW       = 16;
  localparam int DIM       = 3;
  localparam int N_ICFG    = 2;
  localparam int MAX_BURST = 4;
  localparam int ICFG_BW   = 2;
`ifdef CHUNK_ADDR_LOOPER_SPLIT_EN
  localparam int LEN_BW    = 3;
  localparam int BURST     = MAX_BURST;
`else
  localparam int LEN_BW    = GBW;
  localparam int BURST     = 1 << 30;
`endif

  logic                                i_clk = 1'b0;
  logic                                i_rst;
  logic                                i_mofs_rdy;
  logic                                i_mofs_ack;
  logic [DIM-1:0][GBW-1:0]             i_mofs;
  logic [ICFG_BW-1:0]                  i_id;
  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0] i_mlen;
  logic                                o_cmd_rdy;
  logic                                o_cmd_ack;
  logic [DIM-1:0][GBW-1:0]             o_cmd_mofs;
  logic [LEN_BW-1:0]                   o_cmd_len;
  logic [ICFG_BW-1:0]                  o_cmd_id;
  logic                                o_cmd_last;

  chunk_addr_looper #(
    .GBW       (GBW),
    .DIM       (DIM),
    .N_ICFG    (N_ICFG),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_mofs_rdy (i_mofs_rdy),
    .i_mofs_ack (i_mofs_ack),
    .i_mofs     (i_mofs),
    .i_id       (i_id),
    .i_mlen     (i_mlen),
    .o_cmd_rdy  (o_cmd_rdy),
    .o_cmd_ack  (o_cmd_ack),
    .o_cmd_mofs (o_cmd_mofs),
    .o_cmd_len  (o_cmd_len),
    .o_cmd_id   (o_cmd_id),
    .o_cmd_last (o_cmd_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] m0;
    logic [15:0] m1;
    logic [15:0] m2;
    int          len;
    bit          last;
  } cmd_t;

  cmd_t exp_q[$];
  int   cur_id;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference walk: outer dims nested with dim 1 fastest, rows chopped into bursts
  function automatic void build_model(logic [15:0] b0, logic [15:0] b1, logic [15:0] b2,
                                      int l0, int l1, int l2);
    cmd_t c;
    int   w;
    int   n;
    exp_q.delete();
    if (l0 == 0 || l1 == 0 || l2 == 0) return;
    for (int c0 = 0; c0 < l0; c0++) begin
      for (int c1 = 0; c1 < l1; c1++) begin
        w = 0;
        while (w < l2) begin
          n      = (l2 - w > BURST) ? BURST : (l2 - w);
          c.m0   = b0 + 16'(c0);
          c.m1   = b1 + 16'(c1);
          c.m2   = b2 + 16'(w);
          c.len  = n;
          c.last = (c0 == l0 - 1) && (c1 == l1 - 1) && (w + n == l2);
          exp_q.push_back(c);
          w += n;
        end
      end
    end
  endfunction

  task automatic load(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                      input int l0, input int l1, input int l2, input int id);
    i_mofs[0] = b0;
    i_mofs[1] = b1;
    i_mofs[2] = b2;
    for (int k = 0; k < N_ICFG; k++)
      for (int d = 0; d < DIM; d++)
        i_mlen[k][d] = 16'($urandom_range(0, 20));
    i_mlen[id][0] = 16'(l0);
    i_mlen[id][1] = 16'(l1);
    i_mlen[id][2] = 16'(l2);
    i_id   = 2'(id);
    cur_id = id;
    build_model(b0, b1, b2, l0, l1, l2);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the transfer
  task automatic send();
    int t;
    t = 0;
    check("ack_idle_no_rdy", {63'd0, i_mofs_ack}, 64'd1);
    i_mofs_rdy = 1'b1;
    while (i_mofs_ack !== 1'b1 && t < 20) begin
      @(posedge i_clk); @(negedge i_clk);
      t++;
    end
    check("in_ack", {63'd0, i_mofs_ack}, 64'd1);
    @(posedge i_clk); @(negedge i_clk);
    i_mofs_rdy = 1'b0;
  endtask

  task automatic check_cmd(input int k);
    check("cmd_rdy",  {63'd0, o_cmd_rdy}, 64'd1);
    check("cmd_mofs0", 64'(o_cmd_mofs[0]), 64'(exp_q[k].m0));
    check("cmd_mofs1", 64'(o_cmd_mofs[1]), 64'(exp_q[k].m1));
    check("cmd_mofs2", 64'(o_cmd_mofs[2]), 64'(exp_q[k].m2));
    check("cmd_len",  64'(o_cmd_len), 64'(exp_q[k].len));
    check("cmd_id",   64'(o_cmd_id), 64'(cur_id));
    check("cmd_last", {63'd0, o_cmd_last}, {63'd0, exp_q[k].last});
  endtask

  // Consume up to n_take commands; stall_first < 0 means random stall on every command
  task automatic consume(input int n_take, input int stall_first);
    for (int k = 0; k < exp_q.size() && k < n_take; k++) begin
      int st;
      st = (k == 0 && stall_first >= 0) ? stall_first : int'($urandom_range(0, 2));
      for (int s = 0; s <= st; s++) begin
        check_cmd(k);
        if (s == st) o_cmd_ack = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        o_cmd_ack = 1'b0;
      end
    end
    if (n_take >= exp_q.size()) begin
      check("done_rdy", {63'd0, o_cmd_rdy}, 64'd0);
      check("done_ack", {63'd0, i_mofs_ack}, 64'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  {63'd0, o_cmd_rdy}, 64'd0);
    check({tag, "_mofs"}, 64'(o_cmd_mofs), 64'd0);
    check({tag, "_len"},  64'(o_cmd_len), 64'd0);
    check({tag, "_id"},   64'(o_cmd_id), 64'd0);
    check({tag, "_last"}, {63'd0, o_cmd_last}, 64'd0);
    check({tag, "_ack"},  {63'd0, i_mofs_ack}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_a;
    i_rst      = 1'b1;
    i_mofs_rdy = 1'b0;
    i_mofs     = '0;
    i_id       = '0;
    i_mlen     = '0;
    o_cmd_ack  = 1'b0;
    cur_id     = 0;

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    @(posedge i_clk); @(negedge i_clk);

    // Reference chunk: len=(1,2,6), base=(0,10,100), stall-free
    load(16'd0, 16'd10, 16'd100, 1, 2, 6, 0);
    send();
    consume(exp_q.size(), 0);

    // Zero extent: accepted but nothing emitted, then next chunk accepted
    load(16'd5, 16'd6, 16'd7, 2, 0, 3, 1);
    send();
    repeat (4) begin
      check("zero_rdy", {63'd0, o_cmd_rdy}, 64'd0);
      check("zero_ack", {63'd0, i_mofs_ack}, 64'd1);
      @(posedge i_clk); @(negedge i_clk);
    end
    load(16'd20, 16'd30, 16'd40, 2, 1, 5, 1);
    send();
    consume(exp_q.size(), -1);

    // Backpressure: first command held for 5 cycles
    load(16'd0, 16'd10, 16'd100, 1, 2, 6, 1);
    send();
    consume(exp_q.size(), 5);

    // Back-to-back: next chunk offered during the last command of the previous
    load(16'd300, 16'd400, 16'd500, 2, 1, 5, 0);
    send();
    n_a = exp_q.size();
    consume(n_a - 1, -1);
    check_cmd(n_a - 1);
    load(16'd1000, 16'd2000, 16'd3000, 1, 2, 3, 1);
    i_mofs_rdy = 1'b1;
    check("b2b_busy_ack", {63'd0, i_mofs_ack}, 64'd0);
    o_cmd_ack = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    o_cmd_ack = 1'b0;
    check("b2b_gap_rdy", {63'd0, o_cmd_rdy}, 64'd0);
    check("b2b_gap_ack", {63'd0, i_mofs_ack}, 64'd1);
    @(posedge i_clk); @(negedge i_clk);
    i_mofs_rdy = 1'b0;
    consume(exp_q.size(), -1);

    // Reset mid-chunk after one command
    load(16'd0, 16'd10, 16'd100, 1, 2, 6, 1);
    send();
    consume(1, 0);
    i_rst = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    check_all_zero("midrst");
    o_cmd_ack = 1'b1;
    repeat (3) begin
      @(posedge i_clk); @(negedge i_clk);
      check("midrst_quiet", {63'd0, o_cmd_rdy}, 64'd0);
    end
    o_cmd_ack = 1'b0;
    load(16'd7, 16'd8, 16'd9, 1, 1, 3, 0);
    send();
    consume(exp_q.size(), -1);

    // Single long row: len=(1,1,9)
    load(16'd50, 16'd60, 16'd70, 1, 1, 9, 0);
    send();
    consume(exp_q.size(), -1);

    // Randomized chunks, including offset wrap-around
    repeat (8) begin
      load(16'($urandom), 16'($urandom), 16'($urandom),
           int'($urandom_range(1, 2)), int'($urandom_range(1, 3)),
           int'($urandom_range(1, 10)), int'($urandom_range(0, 1)));
      send();
      consume(exp_q.size(), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
